// File: rtl/credit_sender_if.sv
`default_nettype none
// ============================================================================
// Module      : credit_sender_if
// Description : Bus bundle for credit_sender. Carries the upstream
//               Avalon-ST ready/valid stream (avsi_*), the downstream
//               Avalon-ST Credit beat (avso_*), the credit grant/return
//               pair and the flush / status signals.
//               master : view taken by credit_sender itself
//               slave  : view taken by the surrounding environment
//                        (upstream source, credit receiver, control)
// Revision    : 1.0 - initial release
// ============================================================================
interface credit_sender_if #(
    parameter int data_width    = 128,
    parameter int empty_width   = 4,
    parameter int channel_width = 10,
    parameter int credit_width  = 5
) ();
    // Upstream ready/valid stream
    logic [channel_width-1:0] avsi_channel;
    logic [data_width-1:0]    avsi_data;
    logic                     avsi_sop;
    logic                     avsi_eop;
    logic [empty_width-1:0]   avsi_empty;
    logic                     avsi_valid;
    logic                     avsi_ready;

    // Downstream credit-link beat (no backpressure)
    logic [channel_width-1:0] avso_channel;
    logic [data_width-1:0]    avso_data;
    logic                     avso_sop;
    logic                     avso_eop;
    logic [empty_width-1:0]   avso_empty;
    logic                     avso_valid;

    // Credit exchange with the receiver
    logic                     update_credit;
    logic [credit_width-1:0]  credit;
    logic                     return_credit;

    // Control and status
    logic                     flush;
    logic [credit_width:0]    credit_count;
    logic                     credit_overflow;

    modport master (
        input  avsi_channel, avsi_data, avsi_sop, avsi_eop, avsi_empty, avsi_valid,
        output avsi_ready,
        output avso_channel, avso_data, avso_sop, avso_eop, avso_empty, avso_valid,
        input  update_credit, credit,
        output return_credit,
        input  flush,
        output credit_count, credit_overflow
    );

    modport slave (
        output avsi_channel, avsi_data, avsi_sop, avsi_eop, avsi_empty, avsi_valid,
        input  avsi_ready,
        input  avso_channel, avso_data, avso_sop, avso_eop, avso_empty, avso_valid,
        output update_credit, credit,
        input  return_credit,
        output flush,
        input  credit_count, credit_overflow
    );
endinterface
`default_nettype wire

// File: rtl/credit_sender.sv
`default_nettype none
// ============================================================================
// Module      : credit_sender
// Description : Forwards an Avalon-ST ready/valid packet stream over an
//               Avalon-ST Credit link, spending one credit per beat. Credits
//               are granted by the receiver through update_credit/credit.
//               While flush is high, new beats are blocked and every held
//               credit is handed back, one per cycle, on return_credit.
// Ports       : clk            - sole clock
//               reset_n        - asynchronous active-low reset
//               bus (master)   - avsi_* upstream stream, avso_* registered
//                                credit-link beat, update_credit/credit
//                                grant, return_credit pulse, flush level,
//                                credit_count and sticky credit_overflow
// Revision    : 1.0 - initial release
// ============================================================================
module credit_sender #(
    parameter int data_width    = 128,
    parameter int empty_width   = 4,
    parameter int channel_width = 10,
    parameter int credit_width  = 5
) (
    input  wire                   clk,
    input  wire                   reset_n,
    credit_sender_if.master       bus
);

    // Receiver buffer depth; the counter may legitimately hold exactly this.
    localparam logic [credit_width+1:0] c_cmax = (credit_width+2)'(1) << credit_width;

    logic [credit_width:0]      r_cnt;
    logic                       r_overflow;
    logic                       r_return;
    logic                       r_avso_valid;
    logic [channel_width-1:0]   r_avso_channel;
    logic [data_width-1:0]      r_avso_data;
    logic                       r_avso_sop;
    logic                       r_avso_eop;
    logic [empty_width-1:0]     r_avso_empty;

    logic                       w_cnt_nz;
    logic                       w_ready;
    logic                       w_xfer;
    logic                       w_ret;
    logic [credit_width+1:0]    w_grant;
    logic [credit_width+1:0]    w_dec;
    logic [credit_width+1:0]    w_sum;
    logic                       w_over;

    // Ready depends only on registered state and flush, never on avsi_valid.
    assign w_cnt_nz = (r_cnt != '0);
    assign w_ready  = w_cnt_nz & ~bus.flush;
    assign w_xfer   = bus.avsi_valid & w_ready;
    assign w_ret    = bus.flush & w_cnt_nz;

    // One extra bit of headroom so cnt + grant is never truncated before the
    // saturation check. xfer and ret are mutually exclusive (ready is low
    // during flush), so at most one credit leaves per cycle, and only when
    // cnt is non-zero; the subtraction therefore cannot wrap.
    assign w_grant = bus.update_credit ? {2'b00, bus.credit} : '0;
    assign w_dec   = {{(credit_width+1){1'b0}}, w_xfer | w_ret};
    assign w_sum   = {1'b0, r_cnt} + w_grant - w_dec;
    assign w_over  = (w_sum > c_cmax);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_overflow <= 1'b0;
            r_return   <= 1'b0;
        end else begin
            r_cnt      <= w_over ? c_cmax[credit_width:0] : w_sum[credit_width:0];
            r_overflow <= r_overflow | w_over;
            r_return   <= w_ret;
        end
    end

    // Output beat register: valid is reloaded every cycle, payload only moves
    // on a transfer so the bus stays quiet between beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_avso_valid   <= 1'b0;
            r_avso_channel <= '0;
            r_avso_data    <= '0;
            r_avso_sop     <= 1'b0;
            r_avso_eop     <= 1'b0;
            r_avso_empty   <= '0;
        end else begin
            r_avso_valid <= w_xfer;
            if (w_xfer) begin
                r_avso_channel <= bus.avsi_channel;
                r_avso_data    <= bus.avsi_data;
                r_avso_sop     <= bus.avsi_sop;
                r_avso_eop     <= bus.avsi_eop;
                // empty is only meaningful on the last beat of a packet.
                r_avso_empty   <= bus.avsi_eop ? bus.avsi_empty : '0;
            end
        end
    end

    assign bus.avsi_ready      = w_ready;
    assign bus.avso_valid      = r_avso_valid;
    assign bus.avso_channel    = r_avso_channel;
    assign bus.avso_data       = r_avso_data;
    assign bus.avso_sop        = r_avso_sop;
    assign bus.avso_eop        = r_avso_eop;
    assign bus.avso_empty      = r_avso_empty;
    assign bus.return_credit   = r_return;
    assign bus.credit_count    = r_cnt;
    assign bus.credit_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_credit_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_credit_sender
// Description : Self-checking bench for credit_sender. Directed sequences
//               for grant/stream/overflow/reset plus a table of per-cycle
//               vectors covering empty masking and flush credit return.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_credit_sender;

    localparam int c_dw  = 128;
    localparam int c_ew  = 4;
    localparam int c_chw = 10;
    localparam int c_cw  = 5;

    logic clk;
    logic reset_n;

    int n_cmp;
    int n_err;
    logic pre_ready;

    credit_sender_if #(
        .data_width(c_dw), .empty_width(c_ew),
        .channel_width(c_chw), .credit_width(c_cw)
    ) bus ();

    credit_sender #(
        .data_width(c_dw), .empty_width(c_ew),
        .channel_width(c_chw), .credit_width(c_cw)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ucr;
        logic [4:0]  cr;
        logic        v;
        logic        fl;
        logic        eop;
        logic [3:0]  emp;
        logic [7:0]  d;
        logic        e_rdy;
        logic        e_ov;
        logic [3:0]  e_emp;
        logic [7:0]  e_d;
        logic        e_ret;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input int ucr, input int cr, input int v, input int fl,
                                input int eop, input int emp, input int d,
                                input int e_rdy, input int e_ov, input int e_emp,
                                input int e_d, input int e_ret, input int e_cnt);
        vec_t r;
        r.ucr = 1'(ucr);   r.cr = 5'(cr);     r.v = 1'(v);       r.fl = 1'(fl);
        r.eop = 1'(eop);   r.emp = 4'(emp);   r.d = 8'(d);
        r.e_rdy = 1'(e_rdy); r.e_ov = 1'(e_ov); r.e_emp = 4'(e_emp);
        r.e_d = 8'(e_d);   r.e_ret = 1'(e_ret); r.e_cnt = 6'(e_cnt);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs (starting just after a rising edge), capture
    // the combinational ready before the edge, return 1 time unit after it.
    task automatic step(input logic ucr, input logic [4:0] cr, input logic v,
                        input logic fl, input logic [127:0] d, input logic [9:0] ch,
                        input logic sop, input logic eop, input logic [3:0] emp);
        bus.update_credit = ucr;
        bus.credit        = cr;
        bus.avsi_valid    = v;
        bus.flush         = fl;
        bus.avsi_data     = d;
        bus.avsi_channel  = ch;
        bus.avsi_sop      = sop;
        bus.avsi_eop      = eop;
        bus.avsi_empty    = emp;
        #1;
        pre_ready = bus.avsi_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic grant(input logic [4:0] cr);
        step(1'b1, cr, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_cnt",   128'(bus.credit_count), 128'd0);
        chk("rst_ovf",   128'(bus.credit_overflow), 128'd0);
        chk("rst_ready", 128'(bus.avsi_ready), 128'd0);
        chk("rst_ovalid",128'(bus.avso_valid), 128'd0);
        chk("rst_odata", bus.avso_data, 128'd0);
        chk("rst_ochan", 128'(bus.avso_channel), 128'd0);
        chk("rst_oempty",128'(bus.avso_empty), 128'd0);
        chk("rst_osop",  128'(bus.avso_sop), 128'd0);
        chk("rst_oeop",  128'(bus.avso_eop), 128'd0);
        chk("rst_ret",   128'(bus.return_credit), 128'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // The counter is unsigned; a wrap below zero would show up as a value
    // above the buffer depth.
    always @(negedge clk) begin
        if (reset_n) begin
            n_cmp++;
            if (bus.credit_count > 6'd32) begin
                n_err++;
                $display("FAIL cnt_range: got %0d expected <= 32 at %0t", bus.credit_count, $time);
            end
        end
    end

    initial begin
        int acc;
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        bus.update_credit = 1'b0; bus.credit = '0; bus.avsi_valid = 1'b0;
        bus.flush = 1'b0; bus.avsi_data = '0; bus.avsi_channel = '0;
        bus.avsi_sop = 1'b0; bus.avsi_eop = 1'b0; bus.avsi_empty = '0;
        @(posedge clk);
        #1;
        do_reset();

        // ---- single grant of 31, 40 beats offered back-to-back ----
        step(1'b0, 5'd0, 1'b1, 1'b0, 128'd1, 10'd1, 1'b1, 1'b0, 4'd0);
        chk("idle_ready", 128'(pre_ready), 128'd0);
        chk("idle_ovalid", 128'(bus.avso_valid), 128'd0);
        grant(5'd31);
        chk("g31_cnt", 128'(bus.credit_count), 128'd31);
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 5'd0, 1'b1, 1'b0, 128'(100 + i), 10'(i), 1'b0, 1'b0, 4'd0);
            chk("s1_ready", 128'(pre_ready), 128'(i < 31));
            chk("s1_ovalid", 128'(bus.avso_valid), 128'(i < 31));
            chk("s1_cnt", 128'(bus.credit_count), 128'((i < 31) ? (30 - i) : 0));
            chk("s1_odata", bus.avso_data, 128'((i < 31) ? (100 + i) : 130));
            if (i < 31) chk("s1_ochan", 128'(bus.avso_channel), 128'(i));
            if (pre_ready) acc++;
        end
        chk("s1_accepted", 128'(acc), 128'd31);

        // ---- grant arriving with the last credit being spent ----
        grant(5'd1);
        chk("s2_cnt1", 128'(bus.credit_count), 128'd1);
        step(1'b1, 5'd1, 1'b1, 1'b0, 128'h55, 10'h55, 1'b1, 1'b1, 4'd0);
        chk("s2_ready_a", 128'(pre_ready), 128'd1);
        chk("s2_ovalid_a", 128'(bus.avso_valid), 128'd1);
        chk("s2_odata_a", bus.avso_data, 128'h55);
        chk("s2_cnt_a", 128'(bus.credit_count), 128'd1);
        step(1'b0, 5'd0, 1'b1, 1'b0, 128'h66, 10'h66, 1'b1, 1'b1, 4'd0);
        chk("s2_ready_b", 128'(pre_ready), 128'd1);
        chk("s2_ovalid_b", 128'(bus.avso_valid), 128'd1);
        chk("s2_odata_b", bus.avso_data, 128'h66);
        chk("s2_cnt_b", 128'(bus.credit_count), 128'd0);
        step(1'b0, 5'd0, 1'b1, 1'b0, 128'h77, 10'h77, 1'b1, 1'b1, 4'd0);
        chk("s2_ready_c", 128'(pre_ready), 128'd0);
        chk("s2_ovalid_c", 128'(bus.avso_valid), 128'd0);
        chk("s2_odata_c", bus.avso_data, 128'h66);

        // ---- grant 2 every cycle against continuous traffic ----
        step(1'b1, 5'd2, 1'b1, 1'b0, 128'd200, 10'd200, 1'b0, 1'b0, 4'd0);
        chk("s3_ready0", 128'(pre_ready), 128'd0);
        chk("s3_cnt0", 128'(bus.credit_count), 128'd2);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 5'd2, 1'b1, 1'b0, 128'(300 + k), 10'(k + 3), 1'b0, 1'b0, 4'd0);
            chk("s3_ready", 128'(pre_ready), 128'd1);
            chk("s3_ovalid", 128'(bus.avso_valid), 128'd1);
            chk("s3_odata", bus.avso_data, 128'(300 + k));
            chk("s3_ochan", 128'(bus.avso_channel), 128'(k + 3));
            chk("s3_cnt", 128'(bus.credit_count), 128'(3 + k));
        end

        // ---- table: empty masking, then flush from cnt=6, then drain-extend ----
        tbl[0]  = mk(0,0,1,0, 1,5,'hA0, 1,1,5,'hA0,0,9);
        tbl[1]  = mk(0,0,1,0, 0,7,'hA1, 1,1,0,'hA1,0,8);
        tbl[2]  = mk(0,0,1,0, 1,3,'hA2, 1,1,3,'hA2,0,7);
        tbl[3]  = mk(0,0,1,0, 0,0,'hA3, 1,1,0,'hA3,0,6);
        tbl[4]  = mk(0,0,1,1, 1,9,'hB0, 0,0,0,'hA3,1,5);
        tbl[5]  = mk(0,0,1,1, 1,9,'hB1, 0,0,0,'hA3,1,4);
        tbl[6]  = mk(0,0,1,1, 1,9,'hB2, 0,0,0,'hA3,1,3);
        tbl[7]  = mk(0,0,1,1, 1,9,'hB3, 0,0,0,'hA3,1,2);
        tbl[8]  = mk(0,0,1,1, 1,9,'hB4, 0,0,0,'hA3,1,1);
        tbl[9]  = mk(0,0,1,1, 1,9,'hB5, 0,0,0,'hA3,1,0);
        tbl[10] = mk(0,0,1,1, 1,9,'hB6, 0,0,0,'hA3,0,0);
        tbl[11] = mk(0,0,1,1, 1,9,'hB7, 0,0,0,'hA3,0,0);
        tbl[12] = mk(0,0,1,1, 1,9,'hB8, 0,0,0,'hA3,0,0);
        tbl[13] = mk(0,0,1,1, 1,9,'hB9, 0,0,0,'hA3,0,0);
        tbl[14] = mk(0,0,1,0, 0,0,'hC0, 0,0,0,'hA3,0,0);
        tbl[15] = mk(1,3,1,1, 0,0,'hC1, 0,0,0,'hA3,0,3);
        tbl[16] = mk(0,0,1,1, 0,0,'hC2, 0,0,0,'hA3,1,2);
        tbl[17] = mk(0,0,1,1, 0,0,'hC3, 0,0,0,'hA3,1,1);
        tbl[18] = mk(0,0,1,1, 0,0,'hC4, 0,0,0,'hA3,1,0);
        tbl[19] = mk(0,0,0,0, 0,0,'hC5, 0,0,0,'hA3,0,0);
        for (int r = 0; r < 20; r++) begin
            step(tbl[r].ucr, tbl[r].cr, tbl[r].v, tbl[r].fl, 128'(tbl[r].d),
                 10'(tbl[r].d), tbl[r].eop, tbl[r].eop, tbl[r].emp);
            chk("t_ready", 128'(pre_ready), 128'(tbl[r].e_rdy));
            chk("t_ovalid", 128'(bus.avso_valid), 128'(tbl[r].e_ov));
            chk("t_oempty", 128'(bus.avso_empty), 128'(tbl[r].e_emp));
            chk("t_odata", bus.avso_data, 128'(tbl[r].e_d));
            chk("t_ochan", 128'(bus.avso_channel), 128'(tbl[r].e_d));
            chk("t_ret", 128'(bus.return_credit), 128'(tbl[r].e_ret));
            chk("t_cnt", 128'(bus.credit_count), 128'(tbl[r].e_cnt));
        end

        // ---- exact-depth boundary, overflow, saturation, async reset ----
        grant(5'd31);
        grant(5'd1);
        chk("o_cnt32", 128'(bus.credit_count), 128'd32);
        chk("o_noovf", 128'(bus.credit_overflow), 128'd0);
        grant(5'd1);
        chk("o_sat", 128'(bus.credit_count), 128'd32);
        chk("o_ovf", 128'(bus.credit_overflow), 128'd1);
        step(1'b0, 5'd0, 1'b1, 1'b0, 128'hDEAD, 10'h3, 1'b1, 1'b1, 4'd2);
        chk("o_ready", 128'(pre_ready), 128'd1);
        chk("o_cnt31", 128'(bus.credit_count), 128'd31);
        chk("o_sticky", 128'(bus.credit_overflow), 128'd1);
        chk("o_ovalid", 128'(bus.avso_valid), 128'd1);
        bus.avsi_valid = 1'b0;
        do_reset();

        grant(5'd31);
        grant(5'd2);
        chk("o2_sat", 128'(bus.credit_count), 128'd32);
        chk("o2_ovf", 128'(bus.credit_overflow), 128'd1);
        step(1'b0, 5'd0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        chk("o2_sticky", 128'(bus.credit_overflow), 128'd1);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
